ifetch_buf: RTL and testbench

Instruction fetch unit with PC generation and a small prefetch buffer. It sits directly upstream of the if_id register and the decode stage. It issues word requests to instruction memory over a request/grant/response handshake, queues returned instructions with their addresses, and presents one instruction per cycle to if_id. It honours pipeline hold and redirects on jumps or taken branches from execute.

---
 rtl/ifetch_buf.sv | 209 ++++++++++++++++++++
 tb/tb_ifetch_buf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_buf
//  Purpose  : Instruction fetch unit. Generates the PC and issues word
//             requests to instruction memory. Returned instructions are queued
//             with their addresses in a small prefetch FIFO. One instruction
//             per cycle is presented to if_id. Honours downstream hold and
//             redirects (jump / taken branch) coming from execute.
//
//  Ports    : clk           - clock, rising edge
//             rst           - asynchronous reset, active low
//             jump_en_i     - redirect request
//             jump_addr_i   - redirect target (bits [1:0] ignored)
//             hold_i        - downstream stall, head entry not consumed
//             imem_req_o    - fetch request
//             imem_addr_o   - fetch address (word aligned)
//             imem_gnt_i    - request accepted this cycle
//             imem_rvalid_i - response valid
//             imem_rdata_i  - response instruction
//             inst_o        - instruction to if_id
//             inst_addr_o   - address of inst_o
//             inst_valid_o  - inst_o is a real fetched instruction
//
//  Options  : IFETCH_BYPASS_EN - when defined, a response arriving while the
//             FIFO is empty is forwarded combinationally to inst_o.
//
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int unsigned          C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned          C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0]   C_DEPTH = C_CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        fetch_pc_q,  fetch_pc_d;
    logic               pend_q,      pend_d;
    logic [31:0]        pend_addr_q, pend_addr_d;
    logic               drop_q,      drop_d;
    logic [C_PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [C_PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [C_CNT_W-1:0] count_q,     count_d;
    logic [31:0]        entry_addr_q [DEPTH];
    logic [31:0]        entry_inst_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_resp;
    logic [C_CNT_W-1:0] w_credit;
    logic               w_req;
    logic               w_fire;
    logic               w_pop;
    logic               w_bypass;
    logic               w_push;
    logic               w_unused_bits;

    // Word alignment makes the low target bits irrelevant.
    assign w_unused_bits = &{1'b0, jump_addr_i[1:0]};

    // A response without an outstanding request is a protocol error and is
    // ignored entirely.
    assign w_resp   = imem_rvalid_i && pend_q;

    // Entries held plus the one in flight may never exceed the FIFO size, so
    // a push can never find the FIFO full.
    assign w_credit = count_q + C_CNT_W'(pend_q);
    assign w_req    = !jump_en_i && (!pend_q || imem_rvalid_i) && (w_credit < C_DEPTH);
    assign w_fire   = w_req && imem_gnt_i;

    assign w_pop    = (count_q != '0) && !hold_i && !jump_en_i;

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = (count_q == '0) && w_resp && !drop_q && !jump_en_i;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed response that is consumed immediately never enters the FIFO;
    // under hold it is stored so it can be presented again.
    assign w_push   = w_resp && !drop_q && !jump_en_i && !(w_bypass && !hold_i);

    assign imem_req_o  = w_req;
    assign imem_addr_o = fetch_pc_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        drop_d      = drop_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (jump_en_i) begin
            fetch_pc_d = {jump_addr_i[31:2], 2'b00};
        end else if (w_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (w_fire) begin
            pend_d      = 1'b1;
            pend_addr_d = fetch_pc_q;
        end else if (imem_rvalid_i) begin
            pend_d      = 1'b0;
        end

        // The response that was marked stale has arrived; a redirect that
        // leaves a request still in flight marks that one stale instead.
        if (w_resp) begin
            drop_d = 1'b0;
        end
        if (jump_en_i && pend_q && !imem_rvalid_i) begin
            drop_d = 1'b1;
        end

        if (jump_en_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
            end
            count_d = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            drop_q      <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            drop_q      <= drop_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_addr_q[i] <= '0;
                entry_inst_q[i] <= '0;
            end
        end else if (w_push) begin
            entry_addr_q[wr_ptr_q] <= pend_addr_q;
            entry_inst_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Output to if_id
    // ------------------------------------------------------------------
    always_comb begin
        inst_o       = NOP_INST;
        inst_addr_o  = '0;
        inst_valid_o = 1'b0;
        if (w_bypass) begin
            inst_o       = imem_rdata_i;
            inst_addr_o  = pend_addr_q;
            inst_valid_o = 1'b1;
        end else if (count_q != '0) begin
            inst_o       = entry_inst_q[rd_ptr_q];
            inst_addr_o  = entry_addr_q[rd_ptr_q];
            inst_valid_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_buf
//  Purpose  : Self-checking bench for ifetch_buf. A memory model with random
//             grant/response delays feeds the DUT; a reference model tracks
//             the expected fetch stream, buffered instruction count and the
//             stale-response epoch, and every cycle compares the outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_buf;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jaddr;
    logic        hold;
    logic        req;
    logic [31:0] iaddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    always #5 clk = ~clk;

    ifetch_buf #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en),
        .jump_addr_i   (jaddr),
        .hold_i        (hold),
        .imem_req_o    (req),
        .imem_addr_o   (iaddr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .inst_o        (inst),
        .inst_addr_o   (inst_addr),
        .inst_valid_o  (inst_valid)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int          avail;        // instructions buffered, not yet consumed
    logic [31:0] exp_addr;     // next address expected to be consumed
    logic [31:0] exp_fetch;    // next address expected to be requested
    int          epoch = 0;    // bumps on every redirect/reset
    bit          outs;         // memory has a request in flight
    logic [31:0] out_addr;
    int          out_epoch;
    int          rcnt;
    int          gwait;
    int          gmax, rmin, rmax;
    logic [31:0] granted[$];
    int          cyc;
    int          first_valid_cyc;
    logic [31:0] first_valid_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0013_5A00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        avail     = 0;
        exp_addr  = RESET_PC;
        exp_fetch = RESET_PC;
        epoch++;
        outs      = 1'b0;
        rcnt      = 0;
        gwait     = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        hold    = 1'b0;
        jump_en = 1'b0;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        model_reset();
        #1;
        chk("reset inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("reset inst", inst, NOP);
        chk("reset inst_addr", inst_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst             = 1'b1;
        cyc             = 0;
        first_valid_cyc = -1;
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance
    // the model as the rising edge will.
    task automatic step(input bit h, input bit j, input logic [31:0] ja);
        bit vr, exp_valid, exp_req, consume;
        int pre;
        @(negedge clk);
        hold    = h;
        jump_en = j;
        jaddr   = ja;
        rvalid  = outs && (rcnt == 0);
        rdata   = rvalid ? mem_word(out_addr) : $urandom;
        gnt     = 1'b0;
        #1;
        vr        = rvalid && (out_epoch == epoch) && !j;
        pre       = avail;
        exp_valid = (pre > 0) || (BYP && vr && pre == 0);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("inst_addr", inst_addr, exp_addr);
            chk("inst", inst, mem_word(exp_addr));
        end else begin
            chk("empty inst", inst, NOP);
            chk("empty inst_addr", inst_addr, 32'd0);
        end
        exp_req = !j && (!outs || rvalid) && ((pre + int'(outs)) < DEPTH);
        chk("imem_req", {31'b0, req}, {31'b0, exp_req});
        if (req) chk("imem_addr", iaddr, exp_fetch);
        if (inst_valid && first_valid_cyc < 0) begin
            first_valid_cyc  = cyc;
            first_valid_addr = inst_addr;
        end
        gnt = req && (gwait == 0);

        consume = exp_valid && !h && !j;
        if (consume) begin
            exp_addr = exp_addr + 32'd4;
            if (pre > 0) avail--;
        end
        if (vr && !(BYP && pre == 0 && !h)) avail++;
        if (j) begin
            avail     = 0;
            epoch++;
            exp_addr  = {ja[31:2], 2'b00};
            exp_fetch = {ja[31:2], 2'b00};
        end
        if (rvalid) outs = 1'b0;
        else if (outs) rcnt--;
        if (gnt) begin
            outs      = 1'b1;
            out_addr  = iaddr;
            out_epoch = epoch;
            rcnt      = $urandom_range(rmax - 1, rmin - 1);
            exp_fetch = exp_fetch + 32'd4;
            granted.push_back(iaddr);
            gwait     = $urandom_range(gmax, 0);
        end else if (req && gwait > 0) begin
            gwait--;
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b0; hold = 1'b0; jump_en = 1'b0; jaddr = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        gmax = 0; rmin = 1; rmax = 1;

        // Reset release with an immediate-grant, 1-cycle memory
        granted.delete();
        do_reset();
        repeat (6) step(1'b0, 1'b0, 32'h0);
        chk("first valid cycle", first_valid_cyc, BYP ? 32'd1 : 32'd2);
        chk("grant count", {31'b0, granted.size() >= 3}, 32'd1);
        if (granted.size() >= 3) begin
            chk("grant0", granted[0], 32'h0);
            chk("grant1", granted[1], 32'h4);
            chk("grant2", granted[2], 32'h8);
        end

        // Hold for 5 cycles, then release
        repeat (5) step(1'b1, 1'b0, 32'h0);
        chk("hold full credit", {31'b0, req}, 32'd0);
        repeat (6) step(1'b0, 1'b0, 32'h0);

        // Redirect to 0x103 while a request is still in flight
        rmin = 2; rmax = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (outs && rcnt > 0) found = 1'b1;
        end
        chk("jump setup in flight", {31'b0, found}, 32'd1);
        granted.delete();
        step(1'b0, 1'b1, 32'h0000_0103);
        rmin = 1; rmax = 1;
        first_valid_cyc = -1;
        repeat (8) step(1'b0, 1'b0, 32'h0);
        chk("jump grant count", {31'b0, granted.size() >= 1}, 32'd1);
        if (granted.size() >= 1) chk("jump first grant", granted[0], 32'h100);
        chk("jump first valid addr", first_valid_addr, 32'h100);

        // Random delays, random hold, occasional redirect
        gmax = 3; rmin = 1; rmax = 4;
        for (int i = 0; i < 400; i++) begin
            bit h, j;
            h = ($urandom_range(2, 0) == 0);
            j = ($urandom_range(39, 0) == 0);
            step(h, j, $urandom);
        end

        // Address wrap at the top of memory
        gmax = 0; rmin = 1; rmax = 1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        granted.delete();
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (8) step(1'b0, 1'b0, 32'h0);
        chk("wrap grant count", {31'b0, granted.size() >= 3}, 32'd1);
        if (granted.size() >= 3) begin
            chk("wrap grant0", granted[0], 32'hFFFF_FFF8);
            chk("wrap grant1", granted[1], 32'hFFFF_FFFC);
            chk("wrap grant2", granted[2], 32'h0000_0000);
        end

        // Reset in the middle of a random stream
        gmax = 3; rmin = 1; rmax = 4;
        repeat (20) step(($urandom_range(1, 0) == 0), 1'b0, 32'h0);
        do_reset();
        repeat (30) step(($urandom_range(3, 0) == 0), 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
